// File: rtl/tick_monitor.sv
// tick_monitor: watches a periodic one-cycle tick pulse, acquires lock after
// LOCK_CNT consecutive in-window intervals and raises a sticky alarm when a
// locked tick arrives early, goes missing/late or the upstream error is flagged.
// Optional build macro: TICK_MONITOR_ERRIN_EN (err_in participates in fault
// detection; when undefined err_in is ignored and ext_seen stays 0).
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | monitor disabled, waiting for en
// S_ARM    | waiting for the first tick to start interval measurement
// S_ACQUIRE| counting consecutive in-window intervals toward lock
// S_LOCKED | tick stream healthy, every interval checked
// S_FAULT  | alarm raised, waiting for clr

module tick_monitor #(
  parameter int PERIOD   = 50001,
  parameter int TOL      = 2,
  parameter int LOCK_CNT = 4,
  parameter int CBITS    = 16,
  parameter int TCBITS   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              tick,
  input  logic              err_in,
  input  logic              clr,
  output logic              locked,
  output logic              alarm,
  output logic              early_seen,
  output logic              late_seen,
  output logic              ext_seen,
  output logic [TCBITS-1:0] tick_cnt,
  output logic [CBITS-1:0]  last_interval
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_ACQUIRE = 3'd2,
    S_LOCKED  = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  localparam int GBITS = $clog2(LOCK_CNT + 1);
  localparam logic [CBITS-1:0] WIN_LO   = CBITS'(PERIOD - TOL);
  localparam logic [CBITS-1:0] WIN_HI   = CBITS'(PERIOD + TOL);
  localparam logic [GBITS-1:0] GOOD_TOP = GBITS'(LOCK_CNT - 1);

  state_t             state;
  logic [CBITS-1:0]   gcnt;
  logic [GBITS-1:0]   good;
  logic               early;
  logic               late;
  logic               in_win;
  logic               ext_err;

  assign early  = tick && (gcnt < WIN_LO);
  assign late   = (gcnt > WIN_HI);
  assign in_win = tick && !early && !late;

`ifdef TICK_MONITOR_ERRIN_EN
  assign ext_err = err_in;
`else
  logic unused_err_in;
  assign unused_err_in = err_in;
  assign ext_err       = 1'b0;
`endif

  // Gap counter: restarts at 1 on every tick so its value on a tick cycle is the interval.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gcnt <= '0;
    end else if (tick) begin
      gcnt <= CBITS'(1);
    end else if (gcnt != {CBITS{1'b1}}) begin
      gcnt <= gcnt + CBITS'(1);
    end
  end

  // Capture the measured interval on every tick once the monitor is active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_interval <= '0;
    end else if (tick && (state != S_IDLE)) begin
      last_interval <= gcnt;
    end
  end

  // Lock/fault sequencing with registered locked/alarm and sticky cause flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      good       <= '0;
      tick_cnt   <= '0;
      locked     <= 1'b0;
      alarm      <= 1'b0;
      early_seen <= 1'b0;
      late_seen  <= 1'b0;
      ext_seen   <= 1'b0;
    end else if (!en) begin
      state  <= S_IDLE;
      good   <= '0;
      locked <= 1'b0;
      alarm  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_ARM;
        end
        S_ARM: begin
          if (tick) begin
            state <= S_ACQUIRE;
          end
        end
        S_ACQUIRE: begin
          if (early || late || ext_err) begin
            good <= '0;
          end else if (in_win) begin
            tick_cnt <= tick_cnt + TCBITS'(1);
            good     <= good + GBITS'(1);
            if (good == GOOD_TOP) begin
              state  <= S_LOCKED;
              locked <= 1'b1;
            end
          end
        end
        S_LOCKED: begin
          if (early || late || ext_err) begin
            state      <= S_FAULT;
            locked     <= 1'b0;
            alarm      <= 1'b1;
            early_seen <= early_seen | early;
            late_seen  <= late_seen | late;
            ext_seen   <= ext_seen | ext_err;
          end else if (in_win) begin
            tick_cnt <= tick_cnt + TCBITS'(1);
          end
        end
        S_FAULT: begin
          if (clr) begin
            state      <= S_ARM;
            alarm      <= 1'b0;
            good       <= '0;
            early_seen <= 1'b0;
            late_seen  <= 1'b0;
            ext_seen   <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          good   <= '0;
          locked <= 1'b0;
          alarm  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_monitor.sv
// Testbench for tick_monitor: directed scenarios plus randomized tick streams,
// checked cycle by cycle against an event-level reference model via a queue.
module tb_tick_monitor;

  localparam int P     = 10;
  localparam int T     = 1;
  localparam int L     = 2;
  localparam int CB    = 8;
  localparam int TCB   = 8;
  localparam int GMAX  = 255;
`ifdef TICK_MONITOR_ERRIN_EN
  localparam bit ERRIN = 1'b1;
`else
  localparam bit ERRIN = 1'b0;
`endif

  localparam int MI = 0, MA = 1, MQ = 2, ML = 3, MF = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en = 1'b0;
  logic           tick = 1'b0;
  logic           err_in = 1'b0;
  logic           clr = 1'b0;
  logic           locked, alarm, early_seen, late_seen, ext_seen;
  logic [TCB-1:0] tick_cnt;
  logic [CB-1:0]  last_interval;

  tick_monitor #(
    .PERIOD(P), .TOL(T), .LOCK_CNT(L), .CBITS(CB), .TCBITS(TCB)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .tick(tick), .err_in(err_in), .clr(clr),
    .locked(locked), .alarm(alarm), .early_seen(early_seen),
    .late_seen(late_seen), .ext_seen(ext_seen), .tick_cnt(tick_cnt),
    .last_interval(last_interval)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           lk, al, es, ls, xs;
    logic [TCB-1:0] tc;
    logic [CB-1:0]  li;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // reference model state: cycles since last tick, mode, streak, counters
  int m_g = 0, m_mode = MI, m_good = 0, m_tc = 0, m_li = 0;
  bit m_e = 0, m_l = 0, m_x = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp();
    exp_t x;
    x.lk = (m_mode == ML);
    x.al = (m_mode == MF);
    x.es = m_e;
    x.ls = m_l;
    x.xs = m_x;
    x.tc = TCB'(m_tc);
    x.li = CB'(m_li);
    exp_q.push_back(x);
  endtask

  task automatic model_reset();
    m_g = 0; m_mode = MI; m_good = 0; m_tc = 0; m_li = 0;
    m_e = 0; m_l = 0; m_x = 0;
  endtask

  task automatic model_step(input bit e, input bit t, input bit c, input bit x);
    int g;
    bit early, late, inwin, xe;
    g     = m_g;
    early = t && (g < P - T);
    late  = (g > P + T);
    inwin = t && !early && !late;
    xe    = x && ERRIN;
    if (t && m_mode != MI) m_li = g;
    m_g = t ? 1 : ((g + 1 > GMAX) ? GMAX : g + 1);
    if (!e) begin
      m_mode = MI;
      m_good = 0;
    end else begin
      case (m_mode)
        MI: m_mode = MA;
        MA: if (t) m_mode = MQ;
        MQ: begin
          if (early || late || xe) m_good = 0;
          else if (inwin) begin
            m_good++;
            m_tc = (m_tc + 1) % 256;
            if (m_good == L) m_mode = ML;
          end
        end
        ML: begin
          if (early || late || xe) begin
            m_mode = MF;
            m_e = m_e | early;
            m_l = m_l | late;
            m_x = m_x | xe;
          end else if (inwin) m_tc = (m_tc + 1) % 256;
        end
        default: begin
          if (c) begin
            m_mode = MA; m_good = 0; m_e = 0; m_l = 0; m_x = 0;
          end
        end
      endcase
    end
  endtask

  // one cycle of stimulus: drive at negedge, record expectation, wait for next negedge
  task automatic step(input bit e, input bit t, input bit c, input bit x);
    en = e; tick = t; clr = c; err_in = x;
    model_step(e, t, c, x);
    push_exp();
    @(negedge clk);
  endtask

  task automatic gap(input int n);
    repeat (n - 1) step(1, 0, 0, 0);
    step(1, 1, 0, 0);
  endtask

  // asynchronous reset in the middle of the low phase; outputs must clear at once
  task automatic rst_pulse(input string name);
    #2 rst = 1'b1;
    #1 chk(name, {locked, alarm, early_seen, late_seen, ext_seen, tick_cnt, last_interval}, 0);
    en = 1'b0; tick = 1'b0; clr = 1'b0; err_in = 1'b0;
    model_reset();
    push_exp();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // scoreboard monitor: one expectation per clock edge, sampled just after it
  always @(posedge clk) begin
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      checks++;
      if ({locked, alarm, early_seen, late_seen, ext_seen, tick_cnt, last_interval} !==
          {x.lk, x.al, x.es, x.ls, x.xs, x.tc, x.li}) begin
        errors++;
        $display("FAIL scoreboard cyc %0d: got lk=%0b al=%0b es=%0b ls=%0b xs=%0b tc=%0d li=%0d expected lk=%0b al=%0b es=%0b ls=%0b xs=%0b tc=%0d li=%0d",
                 cyc, locked, alarm, early_seen, late_seen, ext_seen, tick_cnt, last_interval,
                 x.lk, x.al, x.es, x.ls, x.xs, x.tc, x.li);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int cd;
    repeat (3) @(negedge clk);
    chk("reset_state", {locked, alarm, early_seen, late_seen, ext_seen, tick_cnt, last_interval}, 0);
    rst = 1'b0;

    // acquire and lock on a clean 10-cycle stream
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    gap(10);
    chk("acq_not_yet_locked", locked, 0);
    gap(10);
    chk("lock_locked", locked, 1);
    chk("lock_tick_cnt", tick_cnt, 2);
    chk("lock_last_interval", last_interval, 10);

    // early tick while locked, then acknowledge
    gap(8);
    chk("early_alarm", alarm, 1);
    chk("early_seen", early_seen, 1);
    chk("early_late_clear", late_seen, 0);
    chk("early_tick_cnt_held", tick_cnt, 2);
    step(1, 0, 1, 0);
    chk("clr_alarm", alarm, 0);
    chk("clr_flags", {early_seen, late_seen, ext_seen}, 0);
    step(1, 1, 0, 0);
    gap(10);
    gap(10);
    chk("relock", locked, 1);

    // missing tick while locked
    repeat (11) step(1, 0, 0, 0);
    chk("late_not_yet", alarm, 0);
    step(1, 0, 0, 0);
    chk("late_alarm", alarm, 1);
    chk("late_seen", late_seen, 1);
    step(1, 0, 1, 0);

    // acquire with an out-of-window interval in the middle
    step(1, 1, 0, 0);
    gap(10);
    gap(13);
    gap(10);
    chk("acq_reset_not_locked", locked, 0);
    gap(10);
    chk("acq_locked", locked, 1);
    chk("acq_tick_cnt", tick_cnt, 7);
    chk("acq_last_interval", last_interval, 10);

    // clr is ignored outside FAULT
    step(1, 0, 1, 0);
    chk("clr_ignored_locked", locked, 1);

    // upstream error while locked
    step(1, 0, 0, 1);
    if (ERRIN) begin
      chk("errin_alarm", alarm, 1);
      chk("errin_ext_seen", ext_seen, 1);
    end else begin
      chk("errin_ignored_locked", locked, 1);
      chk("errin_ext_tied", ext_seen, 0);
    end

    // disable: back to idle, counters hold
    step(0, 0, 0, 0);
    chk("disable_locked", {locked, alarm}, 0);
    chk("disable_tick_cnt_held", tick_cnt, 7);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    gap(10);
    gap(10);
    chk("reen_tick_cnt", tick_cnt, 9);

    // reset mid-interval while locked, then re-acquire from scratch
    repeat (4) step(1, 0, 0, 0);
    rst_pulse("rst_mid_interval");
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    gap(10);
    gap(10);
    chk("post_rst_locked", locked, 1);
    chk("post_rst_tick_cnt", tick_cnt, 2);

    // long silence saturates the gap counter
    repeat (300) step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("sat_last_interval", last_interval, 255);
    chk("sat_alarm_held", alarm, 1);
    step(1, 0, 1, 0);

    // randomized tick streams with occasional clr, err_in, en drops and resets
    cd = 10;
    for (int i = 0; i < 4000; i++) begin
      bit t, e, c, x;
      if ($urandom_range(0, 699) == 0) begin
        rst_pulse("rst_random");
      end else begin
        t = (cd <= 1);
        if (t) begin
          if ($urandom_range(0, 9) < 8) cd = $urandom_range(P - T, P + T);
          else if ($urandom_range(0, 1) == 1) cd = $urandom_range(2, P - T - 1);
          else cd = $urandom_range(P + T + 1, P + T + 6);
        end else begin
          cd--;
        end
        e = ($urandom_range(0, 299) != 0);
        c = ($urandom_range(0, 19) == 0);
        x = ($urandom_range(0, 79) == 0);
        step(e, t, c, x);
      end
    end

    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
